// File: rtl/mcpu_param.sv
// Purpose: parametrised accumulator CPU (NOR/ADD/STA/JCC) on one async-read memory; optional MCPU_WAIT_EN wait-state handshake.
// Latency: NOR/ADD/STA and untaken JCC take 2 cycles, a taken JCC takes 1 cycle (no wait states).
// Backpressure: with MCPU_WAIT_EN, mem_rdy=0 during a strobe freezes all state and bus outputs; otherwise mem_rdy is ignored.
module mcpu_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rdata,
  input  logic              mem_rdy,
  output logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] addr,
  output logic              rd_en,
  output logic              wr_en,
  output logic              carry,
  output logic              halt
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_NOR   = 3'd1,
    S_ADD   = 3'd2,
    S_STA   = 3'd3,
    S_JNT   = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] PC0 = ADDR_W'(RESET_PC);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] acc, acc_nxt;
  logic              carry_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] adreg, adreg_nxt;

  logic [1:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W:0]   sum;
  logic              ready;

  assign opcode  = rdata[DATA_W-1 -: 2];
  assign operand = rdata[ADDR_W-1:0];
  assign sum     = {1'b0, acc} + {1'b0, rdata};

`ifdef MCPU_WAIT_EN
  // Memory may stretch any strobed cycle.
  assign ready = mem_rdy;
`else
  // Every access completes in one cycle.
  logic unused_mem_rdy;
  assign unused_mem_rdy = mem_rdy;
  assign ready = 1'b1;
`endif

  assign wdata = acc;
  assign addr  = adreg;
  assign halt  = (state == S_HALT);

  // Next-state, register updates and bus strobes; nothing advances until the access is accepted.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    carry_nxt = carry;
    pc_nxt    = pc;
    adreg_nxt = adreg;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    case (state)
      S_FETCH: begin
        rd_en = 1'b1;
        if (ready) begin
          pc_nxt    = adreg + 1'b1;
          adreg_nxt = operand;
          case (opcode)
            2'b00: state_nxt = S_NOR;
            2'b01: state_nxt = S_ADD;
            2'b10: state_nxt = S_STA;
            default: begin
              if (carry)                 state_nxt = S_JNT;
              else if (operand == adreg) state_nxt = S_HALT;
              else                       state_nxt = S_FETCH;
            end
          endcase
        end
      end
      S_NOR: begin
        rd_en = 1'b1;
        if (ready) begin
          acc_nxt   = ~(acc | rdata);
          adreg_nxt = pc;
          state_nxt = S_FETCH;
        end
      end
      S_ADD: begin
        rd_en = 1'b1;
        if (ready) begin
          acc_nxt   = sum[DATA_W-1:0];
          carry_nxt = sum[DATA_W];
          adreg_nxt = pc;
          state_nxt = S_FETCH;
        end
      end
      S_STA: begin
        wr_en = 1'b1;
        if (ready) begin
          adreg_nxt = pc;
          state_nxt = S_FETCH;
        end
      end
      S_JNT: begin
        carry_nxt = 1'b0;
        adreg_nxt = pc;
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
    // Strobes drop as soon as reset is asserted, even mid-instruction.
    if (!rst) begin
      rd_en = 1'b0;
      wr_en = 1'b0;
    end
  end

  // Architectural state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_FETCH;
      acc   <= '0;
      carry <= 1'b0;
      pc    <= PC0;
      adreg <= PC0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      carry <= carry_nxt;
      pc    <= pc_nxt;
      adreg <= adreg_nxt;
    end
  end

endmodule
